regfile_scoreboard: RTL and testbench

//  Parametrised integer register file for the pipelined core: NREGS x XLEN storage, two async read ports,
//  one writeback port, plus a per-register busy scoreboard tracking in-flight destination writes.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_scoreboard_if.sv | 29 ++
 rtl/regfile_scoreboard_rf_scoreboard.sv | 50 +++++
 rtl/regfile_scoreboard.sv | 60 ++++++
 tb/tb_regfile_scoreboard.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and index/data types for the register file and its scoreboard.
// Optional build macro used by the RTL: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Decode/issue and writeback signals of the register file, bundled with master/slave views.
// Optional build macro affecting the slave behaviour: REGFILE_BYPASS_EN.
interface regfile_scoreboard_if;
    import regfile_pkg::*;

    reg_idx_t rd_addr1;
    reg_idx_t rd_addr2;
    xword_t   rd_data1;
    xword_t   rd_data2;
    logic     rd_busy1;
    logic     rd_busy2;
    logic     issue_valid;
    reg_idx_t issue_rd;
    logic     issue_ready;
    logic     wb_valid;
    reg_idx_t wb_addr;
    xword_t   wb_data;

    modport master (
        output rd_addr1, rd_addr2, issue_valid, issue_rd, wb_valid, wb_addr, wb_data,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, issue_ready
    );

    modport slave (
        input  rd_addr1, rd_addr2, issue_valid, issue_rd, wb_valid, wb_addr, wb_data,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, issue_ready
    );

endinterface

// File: rtl/regfile_scoreboard_rf_scoreboard.sv
// Per-register busy bits for in-flight destinations, effective-busy queries and issue_ready.
// REGFILE_BYPASS_EN: a register retiring this cycle counts as free.
module rf_scoreboard
    import regfile_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  reg_idx_t i_rs1,
    input  reg_idx_t i_rs2,
    input  reg_idx_t i_rd,
    input  logic     i_issue_valid,
    input  logic     i_wb_valid,
    input  reg_idx_t i_wb_addr,
    output logic     o_eb1,
    output logic     o_eb2,
    output logic     o_issue_ready
);

    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_wb_onehot;
    logic [NREGS-1:0] w_set_onehot;
    logic [NREGS-1:0] w_busy_eff;
    logic             w_fire;

    assign w_wb_onehot  = (i_wb_valid && i_wb_addr != '0) ? (NREGS'(1) << i_wb_addr) : '0;
    assign w_set_onehot = (w_fire && i_rd != '0) ? (NREGS'(1) << i_rd) : '0;

`ifdef REGFILE_BYPASS_EN
    assign w_busy_eff = r_busy & ~w_wb_onehot;
`else
    assign w_busy_eff = r_busy;
`endif

    // Bit 0 is never set, so x0 always reads as free without a special case.
    assign o_eb1         = w_busy_eff[i_rs1];
    assign o_eb2         = w_busy_eff[i_rs2];
    assign o_issue_ready = !o_eb1 && !o_eb2 && !w_busy_eff[i_rd];
    assign w_fire        = i_issue_valid && o_issue_ready;

    // NOTE: one non-blocking update of the whole vector; OR-ing the set after the clear
    // makes a same-cycle claim win over a retiring writeback to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy & ~w_wb_onehot) | w_set_onehot;
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Integer register file: two async read ports, one writeback port, busy scoreboard for issue.
// REGFILE_BYPASS_EN: forward writeback data/busy to the read ports in the same cycle.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_scoreboard_if.slave  bus
);

    xword_t r_regs [NREGS];
    xword_t w_rd_data1;
    xword_t w_rd_data2;
    logic   w_busy1;
    logic   w_busy2;
    logic   w_issue_ready;

    rf_scoreboard u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_rs1         (bus.rd_addr1),
        .i_rs2         (bus.rd_addr2),
        .i_rd          (bus.issue_rd),
        .i_issue_valid (bus.issue_valid),
        .i_wb_valid    (bus.wb_valid),
        .i_wb_addr     (bus.wb_addr),
        .o_eb1         (w_busy1),
        .o_eb2         (w_busy2),
        .o_issue_ready (w_issue_ready)
    );

    // NOTE: the storage is reset on purpose, since reads after reset must return 0;
    // that rules out a plain RAM macro for this array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
        end else if (bus.wb_valid && bus.wb_addr != '0) begin
            r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // NOTE: both outputs get a default on entry so no path through this block infers a latch.
    always_comb begin
        w_rd_data1 = (bus.rd_addr1 == '0) ? '0 : r_regs[bus.rd_addr1];
        w_rd_data2 = (bus.rd_addr2 == '0) ? '0 : r_regs[bus.rd_addr2];
`ifdef REGFILE_BYPASS_EN
        if (bus.wb_valid && bus.wb_addr == bus.rd_addr1 && bus.rd_addr1 != '0)
            w_rd_data1 = bus.wb_data;
        if (bus.wb_valid && bus.wb_addr == bus.rd_addr2 && bus.rd_addr2 != '0)
            w_rd_data2 = bus.wb_data;
`endif
    end

    assign bus.rd_data1    = w_rd_data1;
    assign bus.rd_data2    = w_rd_data2;
    assign bus.rd_busy1    = w_busy1;
    assign bus.rd_busy2    = w_busy2;
    assign bus.issue_ready = w_issue_ready;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: directed hazard cases plus a random issue/wb stream.
// Expectations follow REGFILE_BYPASS_EN when the macro is defined for the build.
module tb_regfile_scoreboard;
    import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef struct {
        string  name;
        xword_t d1;
        xword_t d2;
        logic   b1;
        logic   b2;
        logic   rdy;
    } exp_t;

    logic clk;
    logic rst_n;
    regfile_scoreboard_if bus ();

    regfile_scoreboard dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t   exp_q [$];
    int     checks   = 0;
    int     failures = 0;
    xword_t m_regs [NREGS];
    logic   m_busy [NREGS];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Reference model: architectural state plus the read/ready rules.
    function automatic logic m_eb(input reg_idx_t a, input logic wv, input reg_idx_t wa);
        if (a == '0) return 1'b0;
        if (BYPASS && wv && wa == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic xword_t m_read(input reg_idx_t a, input logic wv, input reg_idx_t wa,
                                      input xword_t wd);
        if (a == '0) return '0;
        if (BYPASS && wv && wa == a) return wd;
        return m_regs[a];
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    // rmode: 0 normal cycle, 1 reset held across the next edge, 2 reset pulse between edges.
    task automatic step(input string name, input reg_idx_t rs1, input reg_idx_t rs2,
                        input logic iv, input reg_idx_t ird, input logic wv,
                        input reg_idx_t wa, input xword_t wd, input int rmode);
        exp_t e;
        logic v_iv;
        logic v_wv;
        logic fire;
        v_iv = (rmode == 0) ? iv : 1'b0;
        v_wv = (rmode == 0) ? wv : 1'b0;
        bus.rd_addr1    = rs1;
        bus.rd_addr2    = rs2;
        bus.issue_valid = v_iv;
        bus.issue_rd    = ird;
        bus.wb_valid    = v_wv;
        bus.wb_addr     = wa;
        bus.wb_data     = wd;
        if (rmode != 0) begin
            rst_n = 1'b0;
            m_reset();
        end else begin
            rst_n = 1'b1;
        end
        e.name = name;
        e.d1   = m_read(rs1, v_wv, wa, wd);
        e.d2   = m_read(rs2, v_wv, wa, wd);
        e.b1   = m_eb(rs1, v_wv, wa);
        e.b2   = m_eb(rs2, v_wv, wa);
        e.rdy  = !e.b1 && !e.b2 && !m_eb(ird, v_wv, wa);
        exp_q.push_back(e);
        if (rmode == 0) begin
            fire = v_iv && e.rdy;
            if (v_wv && wa != '0) begin
                m_regs[wa] = wd;
                m_busy[wa] = 1'b0;
            end
            if (fire && ird != '0) m_busy[ird] = 1'b1;
        end
        if (rmode == 2) begin
            @(negedge clk);
            #1 rst_n = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".rd_data1"},    bus.rd_data1,           e.d1);
            check({e.name, ".rd_data2"},    bus.rd_data2,           e.d2);
            check({e.name, ".rd_busy1"},    32'(bus.rd_busy1),      32'(e.b1));
            check({e.name, ".rd_busy2"},    32'(bus.rd_busy2),      32'(e.b2));
            check({e.name, ".issue_ready"}, 32'(bus.issue_ready),   32'(e.rdy));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reg_idx_t busy_list [$];
        reg_idx_t a;
        reg_idx_t b;
        m_reset();
        rst_n           = 1'b0;
        bus.rd_addr1    = '0;
        bus.rd_addr2    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_addr     = '0;
        bus.wb_data     = '0;
        @(posedge clk);
        #1;

        // Reset held, then released: every address reads 0, not busy, issue ready.
        for (int i = 1; i < NREGS; i += 2)
            step("reset_hold", reg_idx_t'(i), reg_idx_t'(i + 1), 1'b1, reg_idx_t'(i),
                 1'b0, '0, '0, 1);
        for (int i = 1; i < NREGS; i += 2)
            step("reset_release", reg_idx_t'(i), reg_idx_t'(i + 1), 1'b0, reg_idx_t'(i),
                 1'b0, '0, '0, 0);

        // Write/read, and x0 writes are dropped.
        step("wb_x5",      '0, '0, 1'b0, '0, 1'b1, 5, 32'hDEADBEEF, 0);
        step("rd_x5",       5, '0, 1'b0, '0, 1'b0, '0, '0, 0);
        step("wb_x0",       0,  5, 1'b0, '0, 1'b1, 0, 32'h00001234, 0);
        step("rd_x0",       0,  5, 1'b0, '0, 1'b0, '0, '0, 0);

        // RAW on x7.
        step("raw_claim7", '0, '0, 1'b1,  7, 1'b0, '0, '0, 0);
        step("raw_stall",   7, '0, 1'b1, 10, 1'b0, '0, '0, 0);
        step("raw_stall",   7, '0, 1'b1, 10, 1'b0, '0, '0, 0);
        step("raw_wb7",     7, '0, 1'b1, 11, 1'b1,  7, 32'h00000055, 0);
        step("raw_after",   7, '0, 1'b1, 11, 1'b0, '0, '0, 0);
        step("raw_read",    7,  0, 1'b0, '0, 1'b0, '0, '0, 0);

        // WAW on x9, then writeback and reclaim of x9 in one cycle.
        step("waw_claim9", '0, '0, 1'b1,  9, 1'b0, '0, '0, 0);
        step("waw_stall",  '0, '0, 1'b1,  9, 1'b0, '0, '0, 0);
        step("waw_busy",    9, '0, 1'b0, '0, 1'b0, '0, '0, 0);
        step("waw_wb_fire", 9, '0, 1'b1,  9, 1'b1,  9, 32'hA5A5A5A5, 0);
        step("waw_after",   9, '0, 1'b0, '0, 1'b0, '0, '0, 0);

        // Async reset pulse while x3/x4 are claimed.
        step("ar_wb3",     '0, '0, 1'b0, '0, 1'b1,  3, 32'h00000033, 0);
        step("ar_claim3",  '0, '0, 1'b1,  3, 1'b0, '0, '0, 0);
        step("ar_claim4",  '0, '0, 1'b1,  4, 1'b0, '0, '0, 0);
        step("ar_pre",      3,  4, 1'b0,  3, 1'b0, '0, '0, 0);
        step("ar_pulse",    3,  4, 1'b0,  3, 1'b0, '0, '0, 2);
        step("ar_post",     3,  4, 1'b0,  4, 1'b0, '0, '0, 0);

        // Random issue/writeback stream.
        for (int n = 0; n < 400; n++) begin
            busy_list.delete();
            for (int i = 1; i < NREGS; i++)
                if (m_busy[i]) busy_list.push_back(reg_idx_t'(i));
            a = reg_idx_t'($urandom_range(0, NREGS - 1));
            if ($urandom_range(0, 3) == 0) a = '0;
            b = reg_idx_t'($urandom_range(0, NREGS - 1));
            if ($urandom_range(0, 2) == 0) b = '0;
            if (busy_list.size() > 0 && $urandom_range(0, 4) != 0)
                step("rand", a, b, 1'($urandom_range(0, 4) < 3),
                     reg_idx_t'($urandom_range(0, NREGS - 1)), 1'($urandom_range(0, 1)),
                     busy_list[$urandom_range(0, busy_list.size() - 1)], xword_t'($urandom), 0);
            else
                step("rand", a, b, 1'($urandom_range(0, 4) < 3),
                     reg_idx_t'($urandom_range(0, NREGS - 1)), 1'($urandom_range(0, 1)),
                     reg_idx_t'($urandom_range(0, NREGS - 1)), xword_t'($urandom), 0);
        end

        // Retire everything still in flight, then read back the whole file.
        for (int i = 1; i < NREGS; i++)
            if (m_busy[i])
                step("drain_wb", reg_idx_t'(i), '0, 1'b0, '0, 1'b1, reg_idx_t'(i),
                     xword_t'($urandom), 0);
        for (int i = 0; i < NREGS; i += 2)
            step("final_read", reg_idx_t'(i), reg_idx_t'(i + 1), 1'b0, reg_idx_t'(i + 1),
                 1'b0, '0, '0, 0);

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
